// File: rtl/legv8_loader_pkg.sv
// Shared definitions for the LEGv8 program loader: command codes,
// FSM state encoding and default address strides.
package legv8_loader_pkg;

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;

  localparam int IMEM_STRIDE_DEF = 4;
  localparam int DMEM_STRIDE_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CNT     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_WRITE   = 3'd4,
    ST_RUN     = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  function automatic logic is_block_cmd(input logic [7:0] cmd);
    return (cmd == CMD_IMEM) || (cmd == CMD_DMEM);
  endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word assembler: bytes shift in from the top so the
// first byte received ends up in the least significant position.
module word_assembler #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] word,
  output logic             last
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = $clog2(NBYTES);

  logic [CW-1:0] byte_cnt;

  assign last = shift_en && (byte_cnt == CW'(NBYTES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      word     <= {byte_in, word[WIDTH-1:8]};
      byte_cnt <= last ? '0 : byte_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Host byte-stream loader: parses command/count/address headers, assembles
// payload words and writes them into instruction or data memory, then
// releases the CPU from reset on a RUN command.
//
// state   | meaning
// IDLE    | waiting for a command byte
// CNT     | receiving 16-bit word count, LSB first
// ADDR    | receiving 16-bit base byte address, LSB first
// PAYLOAD | assembling the current word
// WRITE   | one-cycle memory write strobe, advance address/count
// RUN     | CPU released, loader idle until reset
// ERR     | illegal command seen, sticky until reset
module program_loader
  import legv8_loader_pkg::*;
#(
  parameter int IMEM_STRIDE = IMEM_STRIDE_DEF,
  parameter int DMEM_STRIDE = DMEM_STRIDE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic        cpu_reset,
  output logic        error
);

  localparam logic [63:0] I_STEP = 64'(IMEM_STRIDE);
  localparam logic [63:0] D_STEP = 64'(DMEM_STRIDE);

  state_t      state, state_nxt;
  logic        accept;
  logic        is_data;
  logic        hdr_idx;
  logic [15:0] count_q;
  logic [63:0] addr_q;
  logic [31:0] word32;
  logic [63:0] word64;
  logic        last32, last64, last_byte;
  logic        shift32, shift64;

  assign accept    = in_valid & in_ready;
  assign shift32   = accept && (state == ST_PAYLOAD) && !is_data;
  assign shift64   = accept && (state == ST_PAYLOAD) && is_data;
  assign last_byte = is_data ? last64 : last32;

  word_assembler #(.WIDTH(32)) u_asm32 (
    .clock    (clock),
    .reset    (reset),
    .shift_en (shift32),
    .byte_in  (in_data),
    .word     (word32),
    .last     (last32)
  );

  word_assembler #(.WIDTH(64)) u_asm64 (
    .clock    (clock),
    .reset    (reset),
    .shift_en (shift64),
    .byte_in  (in_data),
    .word     (word64),
    .last     (last64)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_block_cmd(in_data))  state_nxt = ST_CNT;
          else if (in_data == CMD_RUN) state_nxt = ST_RUN;
          else                         state_nxt = ST_ERR;
        end
      end
      ST_CNT:     if (accept && hdr_idx) state_nxt = ST_ADDR;
      ST_ADDR:    if (accept && hdr_idx) state_nxt = (count_q == 16'd0) ? ST_IDLE : ST_PAYLOAD;
      ST_PAYLOAD: if (last_byte) state_nxt = ST_WRITE;
      ST_WRITE:   state_nxt = (count_q == 16'd1) ? ST_IDLE : ST_PAYLOAD;
      ST_RUN:     state_nxt = ST_RUN;
      ST_ERR:     state_nxt = ST_ERR;
      default:    state_nxt = ST_ERR;
    endcase
  end

  // Strobes are masked by reset so a write pending in the reset cycle is dropped.
  always_comb begin
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    dmem_we   = 1'b0;
    cpu_reset = 1'b1;
    error     = 1'b0;
    case (state)
      ST_IDLE, ST_CNT, ST_ADDR, ST_PAYLOAD: in_ready = 1'b1;
      ST_WRITE: begin
        imem_we = !is_data && !reset;
        dmem_we = is_data && !reset;
      end
      ST_RUN:  cpu_reset = 1'b0;
      ST_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      is_data <= 1'b0;
      hdr_idx <= 1'b0;
      count_q <= '0;
      addr_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) is_data <= (in_data == CMD_DMEM);
        ST_CNT: begin
          if (accept) begin
            hdr_idx <= ~hdr_idx;
            if (hdr_idx) count_q[15:8] <= in_data;
            else         count_q[7:0]  <= in_data;
          end
        end
        ST_ADDR: begin
          if (accept) begin
            hdr_idx <= ~hdr_idx;
            if (hdr_idx) addr_q      <= {48'd0, in_data, addr_q[7:0]};
            else         addr_q[7:0] <= in_data;
          end
        end
        ST_WRITE: begin
          addr_q  <= addr_q + (is_data ? D_STEP : I_STEP);
          count_q <= count_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = addr_q;
  assign dmem_addr  = addr_q;
  assign imem_wdata = word32;
  assign dmem_wdata = word64;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader: streams are decoded by a
// byte-level reference model and the observed memory writes compared to it.
module tb_program_loader;

  localparam int I_STRIDE = 4;
  localparam int D_STRIDE = 8;

  typedef logic [7:0] byte_t;
  typedef struct {
    logic        d;
    logic [63:0] a;
    logic [63:0] w;
    int          lat;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we, dmem_we;
  logic [63:0] imem_addr, dmem_addr;
  logic [31:0] imem_wdata;
  logic [63:0] dmem_wdata;
  logic        cpu_reset, error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;

  byte_t stim_q[$];
  wr_t   exp_q[$];
  wr_t   got_q[$];

  program_loader #(.IMEM_STRIDE(I_STRIDE), .DMEM_STRIDE(D_STRIDE)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .cpu_reset  (cpu_reset),
    .error      (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Write monitor, sampled mid-low-phase.
  always @(negedge clock) begin
    wr_t r;
    #3;
    if (imem_we || dmem_we) begin
      r.d   = dmem_we;
      r.a   = dmem_we ? dmem_addr : imem_addr;
      r.w   = dmem_we ? dmem_wdata : {32'd0, imem_wdata};
      r.lat = cyc - last_acc;
      got_q.push_back(r);
    end
    if (in_valid && in_ready && !reset) last_acc = cyc;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_le(input logic [63:0] v, input int nbytes);
    for (int i = 0; i < nbytes; i++) stim_q.push_back(byte_t'(v >> (8 * i)));
  endtask

  task automatic add_hdr(input byte_t cmd, input logic [15:0] cnt, input logic [15:0] base);
    stim_q.push_back(cmd);
    add_le(64'(cnt), 2);
    add_le(64'(base), 2);
  endtask

  // Reference decode of the whole stream into the expected write list.
  task automatic model_stream();
    int          p, n, bpw;
    logic [63:0] a, d;
    byte_t       c;
    wr_t         r;
    exp_q.delete();
    p = 0;
    while (p < stim_q.size()) begin
      c = stim_q[p];
      p++;
      if (c != 8'h01 && c != 8'h02) break;
      n = int'(stim_q[p]) + 256 * int'(stim_q[p+1]);
      a = 64'(stim_q[p+2]) + 64'd256 * 64'(stim_q[p+3]);
      p += 4;
      bpw = (c == 8'h01) ? 4 : 8;
      for (int w = 0; w < n; w++) begin
        d = '0;
        for (int b = 0; b < bpw; b++) begin
          d = d | (64'(stim_q[p]) << (8 * b));
          p++;
        end
        r.d = (c == 8'h02); r.a = a; r.w = d; r.lat = 1;
        exp_q.push_back(r);
        a = a + 64'((c == 8'h01) ? I_STRIDE : D_STRIDE);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input byte_t b, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 2) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic send_stream(input int mode);
    for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i], pick_gap(mode));
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_kind"}, 64'(got_q[i].d), 64'(exp_q[i].d));
      check({tag, "_addr"}, got_q[i].a, exp_q[i].a);
      check({tag, "_data"}, got_q[i].w, exp_q[i].w);
      check({tag, "_lat"},  64'(got_q[i].lat), 64'(exp_q[i].lat));
    end
  endtask

  task automatic run_stream(input string tag, input int mode);
    model_stream();
    got_q.delete();
    send_stream(mode);
    repeat (4) @(negedge clock);
    compare_writes(tag);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic add_random_block();
    logic [15:0] base;
    int          cnt, bpw;
    byte_t       cmd;
    cmd  = byte_t'($urandom_range(1, 2));
    cnt  = int'($urandom_range(0, 3));
    base = 16'($urandom);
    add_hdr(cmd, 16'(cnt), base);
    bpw = (cmd == 8'h01) ? 4 : 8;
    for (int i = 0; i < cnt * bpw; i++) stim_q.push_back(byte_t'($urandom));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_imem_we",   64'(imem_we),   64'd0);
    check("rst_dmem_we",   64'(dmem_we),   64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_error",     64'(error),     64'd0);

    // Two-word instruction block
    stim_q.delete();
    add_hdr(8'h01, 16'd2, 16'h0000);
    add_le(64'hD21F0020, 4);
    add_le(64'hD2800041, 4);
    run_stream("imem2", 0);
    if (got_q.size() == 2) begin
      check("imem2_w0", got_q[0].w, 64'hD21F0020);
      check("imem2_a1", got_q[1].a, 64'h4);
      check("imem2_w1", got_q[1].w, 64'hD2800041);
    end
    check("imem2_cpu_reset", 64'(cpu_reset), 64'd1);
    check("imem2_idle",      64'(in_ready),  64'd1);

    // Single data doubleword
    stim_q.delete();
    add_hdr(8'h02, 16'd1, 16'h0040);
    add_le(64'h8182838485868788, 8);
    run_stream("dmem1", 1);
    if (got_q.size() == 1) check("dmem1_w0", got_q[0].w, 64'h8182838485868788);

    // Reset after 3 of 4 payload bytes
    stim_q.delete();
    add_hdr(8'h01, 16'd1, 16'h0000);
    add_le(64'hAABBCC, 3);
    got_q.delete();
    send_stream(0);
    do_reset(2);
    repeat (3) @(negedge clock);
    check("midword_rst_nwr", 64'(got_q.size()), 64'd0);
    stim_q.delete();
    add_hdr(8'h01, 16'd1, 16'h0008);
    add_le(64'(32'($urandom)), 4);
    run_stream("after_rst", 0);

    // Reset landing in the WRITE cycle
    stim_q.delete();
    add_hdr(8'h01, 16'd1, 16'h0020);
    add_le(64'h11223344, 4);
    got_q.delete();
    send_stream(0);
    do_reset(1);
    repeat (3) @(negedge clock);
    check("write_rst_nwr", 64'(got_q.size()), 64'd0);

    // 64-bit address growth past 0xFFFF with in_valid toggling
    stim_q.delete();
    add_hdr(8'h02, 16'd2, 16'hFFF8);
    add_le({$urandom, $urandom}, 8);
    add_le({$urandom, $urandom}, 8);
    run_stream("wrap", 2);
    if (got_q.size() == 2) check("wrap_a1", got_q[1].a, 64'h10000);

    // Random back-to-back multi-block streams
    for (int it = 0; it < 6; it++) begin
      stim_q.delete();
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) add_random_block();
      run_stream("rand", 1);
    end

    // Empty block then RUN
    stim_q.delete();
    add_hdr(8'h01, 16'd0, 16'h0010);
    run_stream("empty", 0);
    check("pre_run_cpu_reset", 64'(cpu_reset), 64'd1);
    got_q.delete();
    send_byte(8'h03, 0);
    check("run_cpu_reset", 64'(cpu_reset), 64'd0);
    check("run_in_ready",  64'(in_ready),  64'd0);
    in_valid = 1'b1;
    in_data  = 8'h01;
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    check("run_hold_cpu_reset", 64'(cpu_reset), 64'd0);
    check("run_nwr", 64'(got_q.size()), 64'd0);

    // Illegal command
    do_reset(2);
    check("run_rst_cpu_reset", 64'(cpu_reset), 64'd1);
    got_q.delete();
    send_byte(8'h7F, 0);
    check("err_flag",     64'(error),    64'd1);
    check("err_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = 8'h02;
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    check("err_sticky", 64'(error), 64'd1);
    check("err_nwr", 64'(got_q.size()), 64'd0);
    do_reset(2);
    check("err_rst_flag", 64'(error), 64'd0);
    stim_q.delete();
    add_random_block();
    add_hdr(8'h02, 16'd1, 16'h0100);
    add_le({$urandom, $urandom}, 8);
    run_stream("post_err", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter IMEM_STRIDE, default 4, meaning byte-address increment per instruction word.
REQ-002 The block SHALL have parameter DMEM_STRIDE, default 8, meaning byte-address increment per data doubleword.
REQ-003 The block SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  in  1  host byte valid.
REQ-006 The block SHALL have port in_data  in  8  host byte.
REQ-007 The block SHALL have port in_ready  out  1  loader can accept a byte; transfer occurs when in_valid & in_ready at clock edge.
REQ-008 The block SHALL have ports imem_we out 1, imem_addr out 64, imem_wdata out 32 for the instruction-memory write strobe, byte address and word.
REQ-009 The block SHALL have ports dmem_we out 1, dmem_addr out 64, dmem_wdata out 64 for the data-memory write strobe, byte address and doubleword.
REQ-010 The block SHALL have port cpu_reset  out  1  holds the datapath in reset until a RUN command.
REQ-011 The block SHALL have port error  out  1  sticky protocol-error flag.

Function
REQ-012 Stream format SHALL be: command byte, 16-bit word count (LSB first), 16-bit base byte address (LSB first, zero-extended to 64 bits), then payload bytes LSB first.
REQ-013 Commands SHALL be 0x01 = instruction block (4 bytes/word), 0x02 = data block (8 bytes/word), 0x03 = RUN (no header fields); any other value is illegal.
REQ-014 The FSM SHALL have states IDLE, CNT (2 bytes), ADDR (2 bytes), PAYLOAD, WRITE, RUN, ERR.
REQ-015 Transitions: IDLE->CNT on 0x01/0x02; IDLE->RUN on 0x03; IDLE->ERR on an illegal command; CNT->ADDR after 2 bytes; ADDR->IDLE if count==0, else ADDR->PAYLOAD; PAYLOAD->WRITE when the last byte of a word is accepted; WRITE->PAYLOAD if words remain, else WRITE->IDLE.
REQ-016 in_ready SHALL be 1 in IDLE, CNT, ADDR and PAYLOAD, and 0 in WRITE, RUN and ERR.
REQ-017 In WRITE, exactly one of imem_we or dmem_we SHALL pulse for one cycle, selected by the block's command, with the assembled word and current address; write latency is 1 cycle after the last payload byte is accepted.
REQ-018 After each write, the address SHALL advance by IMEM_STRIDE or DMEM_STRIDE, modulo 2^64 (wrap, no error), and the remaining count SHALL decrement.
REQ-019 The write strobes SHALL be 0 in every state other than WRITE; the addr/wdata outputs are don't-care when their strobe is 0.
REQ-020 cpu_reset SHALL be 1 in all states except RUN; RUN is terminal until reset.
REQ-021 In ERR, error SHALL be 1, no writes SHALL occur, and the state SHALL remain ERR until reset.
REQ-022 in_valid low mid-word SHALL stall assembly without losing accumulated bytes.
REQ-023 Successive blocks SHALL be loadable back-to-back: a new command byte is accepted in IDLE on the cycle after WRITE->IDLE.

Reset
REQ-024 On reset, the state SHALL go to IDLE with in_ready=1, imem_we=0, dmem_we=0, cpu_reset=1, error=0, all counters, address and assembly registers cleared.
REQ-025 Reset mid-block SHALL discard the partial word and SHALL issue no write in the reset cycle or after it.

Structure
REQ-026 Command codes, FSM state encodings and stride defaults SHALL live in a shared package (legv8_loader_pkg).
REQ-027 Byte-to-word assembly SHALL be a sub-module word_assembler (shift register plus byte counter; width parameter of 32 or 64).

Verification
REQ-028 Stream 01 02 00 00 00 | 20 00 1F D2 | 41 00 80 D2 -> imem_we pulses twice: addr 0x0 with data 0xD21F0020, then addr 0x4 with data 0xD2800041; state returns to IDLE; cpu_reset stays 1.
REQ-029 Stream 02 01 00 40 00 + bytes 0x88..0x81 -> one dmem_we pulse at addr 0x40 with data 0x8182838485868788.
REQ-030 Stream 01 00 00 10 00 then 03 -> no writes; cpu_reset falls to 0 one cycle after 0x03 is accepted; in_ready becomes 0.
REQ-031 Command 0x7F -> error=1 and in_ready=0 from the next cycle, with no writes; after reset, error=0 and a legal block loads.
REQ-032 Data block with base 0xFFF8 and count 2, with in_valid toggling every other cycle -> writes at 0xFFF8 and 0x10000 (64-bit address, no 16-bit wrap) with data intact.
REQ-033 Reset asserted after 3 payload bytes of an instruction word -> no imem_we is issued, and the next stream loads from a clean IDLE.
